// File: rtl/hr_timer_pkg.sv
// hr_timer_pkg
// Shared definitions for the high-resolution interval timer master:
//   - register map of the 16-bit, 6-register timer slave
//   - CONTROL / STATUS bit positions
//   - local command opcodes and master FSM state encoding
//   - helpers that build one cycle of Avalon-MM bus drive
// No ports (package).
package hr_timer_pkg;

  // Timer slave register map
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // CONTROL bit positions
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // STATUS bit positions
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_STOP   = 2'd1,
    OP_SNAP   = 2'd2,
    OP_STATUS = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_W_PL   = 4'd1,
    ST_W_PH   = 4'd2,
    ST_W_CTL  = 4'd3,
    ST_W_STOP = 4'd4,
    ST_W_SNAP = 4'd5,
    ST_R_SL0  = 4'd6,
    ST_R_SL1  = 4'd7,
    ST_R_SH0  = 4'd8,
    ST_R_SH1  = 4'd9,
    ST_R_ST0  = 4'd10,
    ST_R_ST1  = 4'd11,
    ST_W_CLR  = 4'd12,
    ST_RESP   = 4'd13
  } state_e;

  // One cycle worth of bus drive, held in a single register.
  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  function automatic bus_t bus_idle();
    bus_t b;
    b.cs      = 1'b0;
    b.write_n = 1'b1;
    b.addr    = 3'd0;
    b.wdata   = 16'h0000;
    return b;
  endfunction

  function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
    bus_t b;
    b.cs      = 1'b1;
    b.write_n = 1'b0;
    b.addr    = addr;
    b.wdata   = data;
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [2:0] addr);
    bus_t b;
    b.cs      = 1'b1;
    b.write_n = 1'b1;
    b.addr    = addr;
    b.wdata   = 16'h0000;
    return b;
  endfunction

  // CONTROL word; the timeout interrupt is always left enabled.
  function automatic logic [15:0] ctl_word(input logic start, input logic stop, input logic cont);
    logic [15:0] w;
    w            = 16'h0000;
    w[CTL_ITO]   = 1'b1;
    w[CTL_CONT]  = cont;
    w[CTL_START] = start;
    w[CTL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/hr_timer_master.sv
// hr_timer_master
// Avalon-MM initiator for the high-resolution interval timer slave. Turns
// local commands (START, STOP, SNAP, STATUS) into register sequences and
// services the timer interrupt autonomously (clears TO, counts expirations).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   cmd_valid/ready/op    - command handshake and opcode
//   cmd_period            - START load value
//   cmd_continuous        - START CONT bit
//   rsp_valid/rsp_data    - one-cycle completion pulse and result
//   timeout_pulse/count   - serviced-interrupt pulse and wrapping counter
//   avm_*                 - registered timer bus, readdata one cycle after address
//   irq                   - level interrupt from the timer
module hr_timer_master
  import hr_timer_pkg::*;
#(
  parameter logic DEFAULT_CONT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        timeout_pulse,
  output logic [15:0] timeout_count,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  input  logic        irq
);

  state_e      state_r;
  bus_t        bus_r;
  logic [31:0] period_r;
  logic        cont_cmd_r;
  logic        cont_q_r;     // CONT bit of the last START, reused by STOP
  logic [15:0] snap_lo_r;

  // A pending interrupt blocks new commands until its clear write is done.
  assign cmd_ready = (state_r == ST_IDLE) && !irq && !reset;

  assign avm_chipselect = bus_r.cs;
  assign avm_write_n    = bus_r.write_n;
  assign avm_address    = bus_r.addr;
  assign avm_writedata  = bus_r.wdata;

  // Master FSM: bus drive is registered together with the state it belongs to,
  // so each state's bus cycle appears in the cycle that state is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      bus_r         <= bus_idle();
      period_r      <= 32'h0000_0000;
      cont_cmd_r    <= 1'b0;
      cont_q_r      <= DEFAULT_CONT;
      snap_lo_r     <= 16'h0000;
      rsp_valid     <= 1'b0;
      rsp_data      <= 32'h0000_0000;
      timeout_pulse <= 1'b0;
      timeout_count <= 16'h0000;
    end else begin
      rsp_valid     <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (irq) begin
            // Interrupt service takes priority over any waiting command.
            state_r <= ST_W_CLR;
            bus_r   <= bus_write(ADDR_STATUS, 16'h0000);
          end else if (cmd_valid && cmd_ready) begin
            period_r   <= cmd_period;
            cont_cmd_r <= cmd_continuous;
            case (cmd_op_e'(cmd_op))
              OP_START: begin
                state_r <= ST_W_PL;
                bus_r   <= bus_write(ADDR_PERIODL, cmd_period[15:0]);
              end
              OP_STOP: begin
                state_r <= ST_W_STOP;
                bus_r   <= bus_write(ADDR_CONTROL, ctl_word(1'b0, 1'b1, cont_q_r));
              end
              OP_SNAP: begin
                // Any write to SNAPL latches the counter into SNAPL/SNAPH.
                state_r <= ST_W_SNAP;
                bus_r   <= bus_write(ADDR_SNAPL, 16'h0000);
              end
              OP_STATUS: begin
                state_r <= ST_R_ST0;
                bus_r   <= bus_read(ADDR_STATUS);
              end
              default: begin
                state_r <= ST_IDLE;
                bus_r   <= bus_idle();
              end
            endcase
          end else begin
            bus_r <= bus_idle();
          end
        end
        ST_W_PL: begin
          state_r <= ST_W_PH;
          bus_r   <= bus_write(ADDR_PERIODH, period_r[31:16]);
        end
        ST_W_PH: begin
          state_r  <= ST_W_CTL;
          bus_r    <= bus_write(ADDR_CONTROL, ctl_word(1'b1, 1'b0, cont_cmd_r));
          cont_q_r <= cont_cmd_r;
        end
        ST_W_CTL, ST_W_STOP: begin
          state_r   <= ST_RESP;
          bus_r     <= bus_idle();
          rsp_valid <= 1'b1;
          rsp_data  <= 32'h0000_0000;
        end
        ST_W_SNAP: begin
          state_r <= ST_R_SL0;
          bus_r   <= bus_read(ADDR_SNAPL);
        end
        ST_R_SL0: begin
          state_r <= ST_R_SL1;
          bus_r   <= bus_read(ADDR_SNAPL);
        end
        ST_R_SL1: begin
          // Readdata for SNAPL is valid at the end of the second read cycle.
          state_r   <= ST_R_SH0;
          bus_r     <= bus_read(ADDR_SNAPH);
          snap_lo_r <= avm_readdata;
        end
        ST_R_SH0: begin
          state_r <= ST_R_SH1;
          bus_r   <= bus_read(ADDR_SNAPH);
        end
        ST_R_SH1: begin
          state_r   <= ST_RESP;
          bus_r     <= bus_idle();
          rsp_valid <= 1'b1;
          rsp_data  <= {avm_readdata, snap_lo_r};
        end
        ST_R_ST0: begin
          state_r <= ST_R_ST1;
          bus_r   <= bus_read(ADDR_STATUS);
        end
        ST_R_ST1: begin
          state_r   <= ST_RESP;
          bus_r     <= bus_idle();
          rsp_valid <= 1'b1;
          rsp_data  <= {30'd0, avm_readdata[STAT_RUN], avm_readdata[STAT_TO]};
        end
        ST_W_CLR: begin
          state_r       <= ST_IDLE;
          bus_r         <= bus_idle();
          timeout_pulse <= 1'b1;
          timeout_count <= timeout_count + 16'd1;
        end
        ST_RESP: begin
          state_r  <= ST_IDLE;
          bus_r    <= bus_idle();
          rsp_data <= 32'h0000_0000;
        end
        default: begin
          state_r <= ST_IDLE;
          bus_r   <= bus_idle();
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hr_timer_master.sv
// tb_hr_timer_master
// Self-checking bench for hr_timer_master: a behavioural timer slave, a
// table of commands, hand sequences for interrupt/collision/reset cases, and
// a scoreboard of expected bus cycles, responses and timeout pulses.
module tb_hr_timer_master;
  import hr_timer_pkg::*;

  localparam logic DEFAULT_CONT = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_continuous;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        timeout_pulse;
  logic [15:0] timeout_count;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = 16'h0000;
  logic        irq;

  hr_timer_master #(.DEFAULT_CONT(DEFAULT_CONT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural timer slave ----------------
  logic        to_r = 1'b0, run_r = 1'b0, ito_r = 1'b0, cont_s = 1'b0;
  logic [15:0] per_l = 16'h0, per_h = 16'h0, snap_lo_m = 16'h0, snap_hi_m = 16'h0;
  logic [31:0] cnt = 32'h0;
  logic        fire = 1'b0;

  assign irq = to_r & ito_r;

  always @(posedge clk) begin
    if (fire) to_r <= 1'b1;
    if (avm_chipselect && !avm_write_n) begin
      case (avm_address)
        3'd0: to_r <= 1'b0;
        3'd1: begin
          ito_r  <= avm_writedata[0];
          cont_s <= avm_writedata[1];
          if (avm_writedata[2]) run_r <= 1'b1;
          else if (avm_writedata[3]) run_r <= 1'b0;
        end
        3'd2: per_l <= avm_writedata;
        3'd3: per_h <= avm_writedata;
        3'd4, 3'd5: begin
          snap_lo_m <= cnt[15:0];
          snap_hi_m <= cnt[31:16];
        end
        default: ;
      endcase
    end
    case (avm_address)
      3'd0: avm_readdata <= {14'd0, run_r, to_r};
      3'd1: avm_readdata <= {12'd0, 2'b00, cont_s, ito_r};
      3'd2: avm_readdata <= per_l;
      3'd3: avm_readdata <= per_h;
      3'd4: avm_readdata <= snap_lo_m;
      3'd5: avm_readdata <= snap_hi_m;
      default: avm_readdata <= 16'h0000;
    endcase
  end

  // ---------------- scoreboard ----------------
  typedef struct { int cyc; logic wr; logic [2:0] addr; logic [15:0] data; } bus_ev_t;
  typedef struct { int cyc; logic [31:0] data; } rsp_ev_t;
  typedef struct { int cyc; logic [15:0] cnt; } to_ev_t;

  bus_ev_t exp_bus[$];
  rsp_ev_t exp_rsp[$];
  to_ev_t  exp_to[$];

  int checks = 0;
  int failures = 0;
  logic        cont_m = DEFAULT_CONT;
  logic [15:0] tc_m = 16'h0000;

  bus_ev_t mb;
  rsp_ev_t mr;
  to_ev_t  mt;

  always @(negedge clk) begin
    if (avm_chipselect) begin
      checks++;
      if (exp_bus.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected cyc=%0d wr=%0b addr=%0d data=0x%0h", cyc, ~avm_write_n, avm_address, avm_writedata);
      end else begin
        mb = exp_bus.pop_front();
        if (mb.cyc != cyc || mb.wr != ~avm_write_n || mb.addr != avm_address ||
            (mb.wr && mb.data != avm_writedata)) begin
          failures++;
          $display("FAIL bus_cycle actual: cyc=%0d wr=%0b addr=%0d data=0x%0h required: cyc=%0d wr=%0b addr=%0d data=0x%0h",
                   cyc, ~avm_write_n, avm_address, avm_writedata, mb.cyc, mb.wr, mb.addr, mb.data);
        end
      end
    end
    if (rsp_valid) begin
      checks++;
      if (exp_rsp.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected cyc=%0d data=0x%0h", cyc, rsp_data);
      end else begin
        mr = exp_rsp.pop_front();
        if (mr.cyc != cyc || mr.data != rsp_data) begin
          failures++;
          $display("FAIL rsp actual: cyc=%0d data=0x%0h required: cyc=%0d data=0x%0h", cyc, rsp_data, mr.cyc, mr.data);
        end
      end
    end
    if (timeout_pulse) begin
      checks++;
      if (exp_to.size() == 0) begin
        failures++;
        $display("FAIL to_unexpected cyc=%0d count=%0d", cyc, timeout_count);
      end else begin
        mt = exp_to.pop_front();
        if (mt.cyc != cyc || mt.cnt != timeout_count) begin
          failures++;
          $display("FAIL timeout actual: cyc=%0d count=%0d required: cyc=%0d count=%0d", cyc, timeout_count, mt.cyc, mt.cnt);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic void push_w(input int c, input logic [2:0] a, input logic [15:0] d);
    exp_bus.push_back('{c, 1'b1, a, d});
  endfunction

  function automatic void push_r(input int c, input logic [2:0] a);
    exp_bus.push_back('{c, 1'b0, a, 16'h0000});
  endfunction

  // Expected traffic for one accepted command; acc is the cycle right after the accept edge.
  function automatic void push_expect(input logic [1:0] op, input int acc, input logic [31:0] per,
                                      input logic c, input logic [31:0] rsp);
    int b;
    b = acc - 1;
    case (op)
      2'd0: begin
        push_w(b + 1, 3'd2, per[15:0]);
        push_w(b + 2, 3'd3, per[31:16]);
        push_w(b + 3, 3'd1, {12'd0, 1'b0, 1'b1, c, 1'b1});
        exp_rsp.push_back('{b + 4, 32'h0});
        cont_m = c;
      end
      2'd1: begin
        push_w(b + 1, 3'd1, {12'd0, 1'b1, 1'b0, cont_m, 1'b1});
        exp_rsp.push_back('{b + 2, 32'h0});
      end
      2'd2: begin
        push_w(b + 1, 3'd4, 16'h0000);
        push_r(b + 2, 3'd4);
        push_r(b + 3, 3'd4);
        push_r(b + 4, 3'd5);
        push_r(b + 5, 3'd5);
        exp_rsp.push_back('{b + 6, rsp});
      end
      default: begin
        push_r(b + 1, 3'd0);
        push_r(b + 2, 3'd0);
        exp_rsp.push_back('{b + 3, rsp});
      end
    endcase
  endfunction

  // e is the cycle in which irq first reads high while the master is idle.
  function automatic void push_clear(input int e);
    push_w(e + 1, 3'd0, 16'h0000);
    tc_m = tc_m + 16'd1;
    exp_to.push_back('{e + 2, tc_m});
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] per, input logic c,
                          input logic with_to, output int acc);
    int n;
    n = 0;
    acc = -100;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_period = per;
    cmd_continuous = c;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout op=%0d", op);
      cmd_valid = 1'b0;
    end else begin
      fire = with_to;
      @(posedge clk);
      #1;
      acc = cyc;
      cmd_valid = 1'b0;
      fire = 1'b0;
    end
  endtask

  task automatic fire_to();
    int e;
    @(negedge clk);
    fire = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    fire = 1'b0;
    push_clear(e);
  endtask

  typedef struct { logic [1:0] op; logic [31:0] per; logic c; logic [31:0] cnt_val; logic [31:0] rsp; } vec_t;
  vec_t vecs[9];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acc;
    vecs[0] = '{2'd0, 32'h0001_86A0, 1'b1, 32'h0,         32'h0};
    vecs[1] = '{2'd2, 32'h0,         1'b0, 32'h0000_1234, 32'h0000_1234};
    vecs[2] = '{2'd3, 32'h0,         1'b0, 32'h0,         32'h0000_0002};
    vecs[3] = '{2'd1, 32'h0,         1'b0, 32'h0,         32'h0};
    vecs[4] = '{2'd3, 32'h0,         1'b0, 32'h0,         32'h0000_0000};
    vecs[5] = '{2'd0, 32'h0000_0005, 1'b0, 32'h0,         32'h0};
    vecs[6] = '{2'd1, 32'h0,         1'b0, 32'h0,         32'h0};
    vecs[7] = '{2'd2, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[8] = '{2'd0, 32'h1234_5678, 1'b1, 32'h0,         32'h0};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_period = 32'h0;
    cmd_continuous = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_write_n", {31'd0, avm_write_n}, 32'd1);
    chk("rst_cs", {31'd0, avm_chipselect}, 32'd0);
    chk("rst_addr_data", {13'd0, avm_address, avm_writedata}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_to_count", {16'd0, timeout_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      cnt = vecs[i].cnt_val;
      send_cmd(vecs[i].op, vecs[i].per, vecs[i].c, 1'b0, acc);
      push_expect(vecs[i].op, acc, vecs[i].per, vecs[i].c, vecs[i].rsp);
      repeat (8) @(negedge clk);
    end

    // Three expirations in continuous mode
    for (int k = 0; k < 3; k++) begin
      fire_to();
      repeat (3) @(negedge clk);
      chk("irq_low_after_clear", {31'd0, irq}, 32'd0);
      repeat (3) @(negedge clk);
    end
    chk("to_count_3", {16'd0, timeout_count}, 32'd3);

    // STATUS with TO raised at accept: read sees RUN=1,TO=1, then the irq is serviced
    send_cmd(2'd3, 32'h0, 1'b0, 1'b1, acc);
    push_expect(2'd3, acc, 32'h0, 1'b0, 32'h0000_0003);
    push_clear(acc + 3);
    repeat (10) @(negedge clk);

    // irq pending while STOP is presented: clear first, STOP afterwards
    fire_to();
    send_cmd(2'd1, 32'h0, 1'b0, 1'b0, acc);
    push_expect(2'd1, acc, 32'h0, 1'b0, 32'h0);
    repeat (6) @(negedge clk);
    chk("to_count_5", {16'd0, timeout_count}, 32'd5);

    // Reset during the second SNAPL read cycle
    cnt = 32'h00AB_CDEF;
    send_cmd(2'd2, 32'h0, 1'b0, 1'b0, acc);
    push_w(acc, 3'd4, 16'h0000);
    push_r(acc + 1, 3'd4);
    push_r(acc + 2, 3'd4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_bus_idle", {30'd0, avm_chipselect, avm_write_n}, 32'd1);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("abort_to_count", {16'd0, timeout_count}, 32'd0);
    cont_m = DEFAULT_CONT;
    tc_m = 16'h0000;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(2'd2, 32'h0, 1'b0, 1'b0, acc);
    push_expect(2'd2, acc, 32'h0, 1'b0, 32'h00AB_CDEF);
    repeat (8) @(negedge clk);
    send_cmd(2'd1, 32'h0, 1'b0, 1'b0, acc);
    push_expect(2'd1, acc, 32'h0, 1'b0, 32'h0);
    repeat (10) @(negedge clk);

    chk("bus_queue_drained", exp_bus.size(), 32'd0);
    chk("rsp_queue_drained", exp_rsp.size(), 32'd0);
    chk("to_queue_drained", exp_to.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
